// File: rtl/serial_deserializer.sv
// serial_deserializer
//   Collects the registered serial bit stream from the upstream input flop into
//   WIDTH-bit words and offers each finished word on a valid/ready handshake.
//   A word that finishes while the previous one is still unaccepted is dropped,
//   and the sticky overrun flag is raised.
//
// Parameters
//   WIDTH      word width in bits (2..32)
//   MSB_FIRST  1: first received bit lands in outData[WIDTH-1]
//              0: first received bit lands in outData[0]
//
// Ports
//   inClk       clock, rising edge
//   inRst       synchronous active-high reset
//   inD         serial data bit
//   inEn        qualifies inD; a bit is consumed only when high
//   inSync      start-of-word marker; drops any partial word
//   inReady     downstream accepts outData when outValid is also high
//   outData     completed word, stable while outValid is high
//   outValid    a completed word is held on outData
//   outBusy     partial word in progress (combinational from the bit counter)
//   outOverrun  sticky, a completed word was dropped

module serial_deserializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             inClk,
    input  logic             inRst,
    input  logic             inD,
    input  logic             inEn,
    input  logic             inSync,
    input  logic             inReady,
    output logic [WIDTH-1:0] outData,
    output logic             outValid,
    output logic             outBusy,
    output logic             outOverrun
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] srNext;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic [WIDTH-1:0] dataNext;
    logic             validNext;
    logic             overrunNext;
    logic             wordDone;

    // Shift register with the incoming bit already merged in; the completed
    // word is taken from here so it includes the bit sampled on this edge.
    always_comb begin
        shifted = sr;
        if (MSB_FIRST) begin
            shifted = {sr[WIDTH-2:0], inD};
        end else begin
            shifted = {inD, sr[WIDTH-1:1]};
        end
    end

    // Bit intake, word completion, resync and output handshake.
    always_comb begin
        srNext      = sr;
        cntNext     = cnt;
        dataNext    = outData;
        validNext   = outValid;
        overrunNext = outOverrun;
        wordDone    = 1'b0;

        if (inEn) begin
            srNext = shifted;
            if (inSync) begin
                // Current bit starts a fresh word; stale bits in sr are
                // shifted out before this word completes.
                cntNext = CNT_ONE;
            end else if (cnt == CNT_LAST) begin
                wordDone = 1'b1;
                cntNext  = '0;
            end else begin
                cntNext = cnt + CNT_ONE;
            end
        end else if (inSync) begin
            cntNext = '0;
        end

        if (wordDone) begin
            if (!outValid || inReady) begin
                dataNext  = shifted;
                validNext = 1'b1;
            end else begin
                overrunNext = 1'b1;
            end
        end else if (outValid && inReady) begin
            validNext = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge inClk) begin
        if (inRst) begin
            sr         <= '0;
            cnt        <= '0;
            outData    <= '0;
            outValid   <= 1'b0;
            outOverrun <= 1'b0;
        end else begin
            sr         <= srNext;
            cnt        <= cntNext;
            outData    <= dataNext;
            outValid   <= validNext;
            outOverrun <= overrunNext;
        end
    end

    assign outBusy = (cnt != '0);

endmodule
